// File: rtl/vga_pkg.sv
// Shared VGA-domain types and constants: image width, scheduler states, 640x480 timing.
package vga_pkg;

  localparam int unsigned IMG_W = 256;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_TOTAL  = 525;

  typedef enum logic [2:0] {
    IDLE,
    RUN_EQ,
    WAIT_VB,
    COMMIT,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/vblank_edge_detector.sv
// Registers vblank every cycle and flags its rising edge; reusable by VGA-domain blocks.
module vblank_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic i_vblank,
  output logic o_vb_rise
);

  logic r_vblank_q;

  always_ff @(posedge clk) begin
    if (!rst) r_vblank_q <= 1'b0;
    else      r_vblank_q <= i_vblank;
  end

  assign o_vb_rise = i_vblank & ~r_vblank_q;

endmodule

// File: rtl/vga_image_scheduler.sv
// Runs one equalization pass per source image and commits the Old/New display pair
// only on a vblank rising edge, then holds it for HOLD_FRAMES frames.
module vga_image_scheduler #(
  parameter int unsigned IMG_W       = vga_pkg::IMG_W,
  parameter int unsigned EQ_TIMEOUT  = 1024,
  parameter int unsigned HOLD_FRAMES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblank,
  input  logic             src_valid,
  input  logic [IMG_W-1:0] src_image,
  output logic             src_ready,
  output logic             eq_start,
  output logic [IMG_W-1:0] eq_image,
  input  logic             eq_done,
  input  logic [IMG_W-1:0] eq_result,
  output logic [IMG_W-1:0] disp_old,
  output logic [IMG_W-1:0] disp_new,
  output logic             commit,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt
);
  import vga_pkg::*;

  localparam int unsigned      WDOG_W  = $clog2(EQ_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t     r_state;
  logic [IMG_W-1:0] r_shadow_old;
  logic [IMG_W-1:0] r_shadow_new;
  logic [IMG_W-1:0] r_eq_image;
  logic [IMG_W-1:0] r_disp_old;
  logic [IMG_W-1:0] r_disp_new;
  logic [WDOG_W-1:0] r_wdog;
  logic             r_eq_start;
  logic             r_commit;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             w_vb_rise;
  logic [CNT_W-1:0] w_frame_inc;

  vblank_edge_detector u_vb_edge (
    .clk       (clk),
    .rst       (rst),
    .i_vblank  (vblank),
    .o_vb_rise (w_vb_rise)
  );

  assign w_frame_inc = (r_frame_cnt == CNT_MAX) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_shadow_old  <= '0;
      r_shadow_new  <= '0;
      r_eq_image    <= '0;
      r_disp_old    <= '0;
      r_disp_new    <= '0;
      r_wdog        <= '0;
      r_eq_start    <= 1'b0;
      r_commit      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_eq_start <= 1'b0;
      r_commit   <= 1'b0;
      if (w_vb_rise && (r_state != COMMIT)) r_frame_cnt <= w_frame_inc;

      case (r_state)
        IDLE: begin
          if (src_valid) begin
            r_shadow_old  <= src_image;
            r_eq_image    <= src_image;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
            r_eq_start    <= 1'b1;
            r_state       <= RUN_EQ;
          end
        end
        // eq_done takes priority over a watchdog expiry in the same cycle
        RUN_EQ: begin
          if (eq_done) begin
            r_shadow_new <= eq_result;
            r_state      <= WAIT_VB;
          end else if (r_wdog == WDOG_W'(EQ_TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        // Display pair and commit pulse become visible together in the COMMIT cycle
        WAIT_VB: begin
          if (w_vb_rise) begin
            r_disp_old  <= r_shadow_old;
            r_disp_new  <= r_shadow_new;
            r_commit    <= 1'b1;
            r_frame_cnt <= '0;
            r_state     <= COMMIT;
          end
        end
        COMMIT: begin
          r_state <= (HOLD_FRAMES == 0) ? IDLE : HOLD;
        end
        HOLD: begin
          if (w_vb_rise && (w_frame_inc == CNT_W'(HOLD_FRAMES))) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign src_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign eq_start    = r_eq_start;
  assign eq_image    = r_eq_image;
  assign disp_old    = r_disp_old;
  assign disp_new    = r_disp_new;
  assign commit      = r_commit;
  assign timeout_err = r_timeout_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_image_scheduler.sv
// Directed bench for vga_image_scheduler: one HOLD_FRAMES=2 instance and one HOLD_FRAMES=0 instance.
module tb_vga_image_scheduler;

  localparam int unsigned W = vga_pkg::IMG_W;

  localparam logic [W-1:0] IMG_A = {32{8'hA5}};
  localparam logic [W-1:0] IMG_5 = {32{8'h5A}};
  localparam logic [W-1:0] IMG_B = {32{8'h3C}};
  localparam logic [W-1:0] IMG_C = {32{8'h11}};
  localparam logic [W-1:0] IMG_D = {32{8'h22}};
  localparam logic [W-1:0] IMG_E = {32{8'h77}};
  localparam logic [W-1:0] IMG_F = {32{8'h99}};
  localparam logic [W-1:0] IMG_G = {32{8'hC3}};
  localparam logic [W-1:0] IMG_H = {32{8'hEE}};

  logic clk = 1'b0;
  logic rst;

  logic         vblank, src_valid, src_ready, eq_start, eq_done, commit, busy, timeout_err;
  logic [W-1:0] src_image, eq_image, eq_result, disp_old, disp_new;
  logic [15:0]  frame_cnt;

  logic         vblank0, src_valid0, src_ready0, eq_start0, eq_done0, commit0, busy0, timeout_err0;
  logic [W-1:0] src_image0, eq_image0, eq_result0, disp_old0, disp_new0;
  logic [3:0]   frame_cnt0;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_starts  = 0;
  int n_commits = 0;
  int n0, nc0;

  always #5 clk = ~clk;

  vga_image_scheduler #(.IMG_W(W), .EQ_TIMEOUT(16), .HOLD_FRAMES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .vblank(vblank), .src_valid(src_valid), .src_image(src_image),
    .src_ready(src_ready), .eq_start(eq_start), .eq_image(eq_image), .eq_done(eq_done),
    .eq_result(eq_result), .disp_old(disp_old), .disp_new(disp_new), .commit(commit),
    .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  vga_image_scheduler #(.IMG_W(W), .EQ_TIMEOUT(16), .HOLD_FRAMES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .vblank(vblank0), .src_valid(src_valid0), .src_image(src_image0),
    .src_ready(src_ready0), .eq_start(eq_start0), .eq_image(eq_image0), .eq_done(eq_done0),
    .eq_result(eq_result0), .disp_old(disp_old0), .disp_new(disp_new0), .commit(commit0),
    .busy(busy0), .timeout_err(timeout_err0), .frame_cnt(frame_cnt0)
  );

  // Pulse counters sample the value held during the cycle that ends at this edge
  always @(posedge clk) begin
    if (eq_start) n_starts++;
    if (commit)   n_commits++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    vblank = 1'b0; src_valid = 1'b0; src_image = '0; eq_done = 1'b0; eq_result = '0;
    vblank0 = 1'b0; src_valid0 = 1'b0; src_image0 = '0; eq_done0 = 1'b0; eq_result0 = '0;
    step(2);
    check_eq("rst_src_ready", 256'(src_ready), 256'd1);
    check_eq("rst_busy", 256'(busy), 256'd0);
    check_eq("rst_eq_start", 256'(eq_start), 256'd0);
    check_eq("rst_commit", 256'(commit), 256'd0);
    check_eq("rst_timeout", 256'(timeout_err), 256'd0);
    check_eq("rst_frame_cnt", 256'(frame_cnt), 256'd0);
    check_eq("rst_disp_old", 256'(disp_old), 256'd0);
    check_eq("rst_disp_new", 256'(disp_new), 256'd0);
    check_eq("rst_eq_image", 256'(eq_image), 256'd0);
    rst = 1'b1;
    step(1);
    check_eq("post_rst_ready", 256'(src_ready), 256'd1);

    // Timeout: no eq_done, EQ_TIMEOUT=16
    src_valid = 1'b1; src_image = IMG_B;
    step(1);
    check_eq("to_eq_start", 256'(eq_start), 256'd1);
    check_eq("to_eq_image", 256'(eq_image), 256'(IMG_B));
    check_eq("to_ready_low", 256'(src_ready), 256'd0);
    src_valid = 1'b0;
    step(15);
    check_eq("to_not_yet", 256'(timeout_err), 256'd0);
    check_eq("to_busy", 256'(busy), 256'd1);
    step(1);
    check_eq("to_err", 256'(timeout_err), 256'd1);
    check_eq("to_idle", 256'(src_ready), 256'd1);
    check_eq("to_disp_old", 256'(disp_old), 256'd0);
    check_eq("to_disp_new", 256'(disp_new), 256'd0);

    // Nominal pass
    src_valid = 1'b1; src_image = IMG_A;
    step(1);
    check_eq("nom_eq_start", 256'(eq_start), 256'd1);
    check_eq("nom_to_cleared", 256'(timeout_err), 256'd0);
    check_eq("nom_eq_image", 256'(eq_image), 256'(IMG_A));
    src_valid = 1'b0;
    step(1);
    check_eq("nom_eq_start_1cyc", 256'(eq_start), 256'd0);
    step(9);
    eq_done = 1'b1; eq_result = IMG_5;
    step(1);
    eq_done = 1'b0; eq_result = '0;
    step(19);
    check_eq("nom_no_commit_yet", 256'(commit), 256'd0);
    check_eq("nom_disp_unchanged", 256'(disp_new), 256'd0);
    vb_pulse();
    check_eq("nom_commit", 256'(commit), 256'd1);
    check_eq("nom_disp_old", 256'(disp_old), 256'(IMG_A));
    check_eq("nom_disp_new", 256'(disp_new), 256'(IMG_5));
    check_eq("nom_frame_clr", 256'(frame_cnt), 256'd0);
    step(1);
    check_eq("nom_commit_1cyc", 256'(commit), 256'd0);
    step(2);
    check_eq("nom_hold_ready", 256'(src_ready), 256'd0);
    vb_pulse();
    check_eq("nom_frame_1", 256'(frame_cnt), 256'd1);
    check_eq("nom_hold_ready1", 256'(src_ready), 256'd0);
    step(2);
    vb_pulse();
    check_eq("nom_frame_2", 256'(frame_cnt), 256'd2);
    check_eq("nom_ready_back", 256'(src_ready), 256'd1);
    step(2);

    // Coincident: eq_done on the last watchdog cycle together with a vblank rise
    src_valid = 1'b1; src_image = IMG_C;
    step(1);
    src_valid = 1'b0;
    step(15);
    eq_done = 1'b1; eq_result = IMG_D; vblank = 1'b1;
    step(1);
    eq_done = 1'b0;
    check_eq("co_no_timeout", 256'(timeout_err), 256'd0);
    check_eq("co_busy", 256'(busy), 256'd1);
    check_eq("co_no_commit0", 256'(commit), 256'd0);
    step(1);
    vblank = 1'b0;
    check_eq("co_no_commit1", 256'(commit), 256'd0);
    step(2);
    vb_pulse();
    check_eq("co_commit", 256'(commit), 256'd1);
    check_eq("co_disp_old", 256'(disp_old), 256'(IMG_C));
    check_eq("co_disp_new", 256'(disp_new), 256'(IMG_D));
    step(1);

    // Backpressure: src_valid held through HOLD, RUN_EQ and WAIT_VB
    n0 = n_starts;
    src_valid = 1'b1; src_image = IMG_E;
    step(2);
    check_eq("bp_hold_ready", 256'(src_ready), 256'd0);
    vb_pulse();
    check_eq("bp_hold_ready1", 256'(src_ready), 256'd0);
    step(2);
    vb_pulse();
    check_eq("bp_idle_ready", 256'(src_ready), 256'd1);
    step(1);
    check_eq("bp_eq_start", 256'(eq_start), 256'd1);
    check_eq("bp_eq_image", 256'(eq_image), 256'(IMG_E));
    src_image = IMG_F;
    step(2);
    check_eq("bp_run_ready", 256'(src_ready), 256'd0);
    check_eq("bp_one_start", 256'(n_starts), 256'(n0 + 1));
    eq_done = 1'b1; eq_result = IMG_G;
    step(1);
    eq_done = 1'b0;
    step(2);
    check_eq("bp_wait_ready", 256'(src_ready), 256'd0);
    check_eq("bp_eq_image_stable", 256'(eq_image), 256'(IMG_E));
    vb_pulse();
    check_eq("bp_commit", 256'(commit), 256'd1);
    check_eq("bp_disp_old", 256'(disp_old), 256'(IMG_E));
    check_eq("bp_disp_new", 256'(disp_new), 256'(IMG_G));
    step(2);
    vb_pulse();
    step(2);
    vb_pulse();
    check_eq("bp_idle_again", 256'(src_ready), 256'd1);
    step(1);
    check_eq("bp_second_start", 256'(eq_start), 256'd1);
    check_eq("bp_second_image", 256'(eq_image), 256'(IMG_F));
    src_valid = 1'b0;
    step(2);
    check_eq("bp_two_starts", 256'(n_starts), 256'(n0 + 2));

    // Reset while in RUN_EQ, then a late eq_done
    nc0 = n_commits;
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check_eq("rr_busy", 256'(busy), 256'd0);
    check_eq("rr_ready", 256'(src_ready), 256'd1);
    check_eq("rr_eq_start", 256'(eq_start), 256'd0);
    check_eq("rr_eq_image", 256'(eq_image), 256'd0);
    check_eq("rr_disp_old", 256'(disp_old), 256'd0);
    check_eq("rr_disp_new", 256'(disp_new), 256'd0);
    check_eq("rr_frame_cnt", 256'(frame_cnt), 256'd0);
    eq_done = 1'b1; eq_result = IMG_H;
    step(1);
    eq_done = 1'b0;
    check_eq("rr_late_done_busy", 256'(busy), 256'd0);
    vb_pulse();
    check_eq("rr_no_commit", 256'(commit), 256'd0);
    check_eq("rr_disp_new_kept", 256'(disp_new), 256'd0);
    step(2);

    // Reset while in HOLD; eq_done arrives in the eq_start cycle
    src_valid = 1'b1; src_image = IMG_A;
    step(1);
    src_valid = 1'b0;
    eq_done = 1'b1; eq_result = IMG_B;
    step(1);
    eq_done = 1'b0;
    vb_pulse();
    check_eq("rh_commit", 256'(commit), 256'd1);
    check_eq("rh_disp_new", 256'(disp_new), 256'(IMG_B));
    step(2);
    check_eq("rh_in_hold", 256'(busy), 256'd1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check_eq("rh_busy", 256'(busy), 256'd0);
    check_eq("rh_disp_old", 256'(disp_old), 256'd0);
    check_eq("rh_disp_new", 256'(disp_new), 256'd0);
    check_eq("rh_frame_cnt", 256'(frame_cnt), 256'd0);
    vb_pulse();
    check_eq("rh_no_commit", 256'(commit), 256'd0);
    step(2);
    check_eq("rh_commit_count", 256'(n_commits), 256'(nc0 + 1));

    // HOLD_FRAMES=0 instance with a 4-bit frame counter
    src_valid0 = 1'b1; src_image0 = IMG_A;
    step(1);
    src_valid0 = 1'b0;
    check_eq("h0_eq_start", 256'(eq_start0), 256'd1);
    check_eq("h0_eq_image", 256'(eq_image0), 256'(IMG_A));
    eq_done0 = 1'b1; eq_result0 = IMG_D;
    step(1);
    eq_done0 = 1'b0;
    vblank0 = 1'b1;
    step(1);
    vblank0 = 1'b0;
    check_eq("h0_commit", 256'(commit0), 256'd1);
    check_eq("h0_disp_old", 256'(disp_old0), 256'(IMG_A));
    check_eq("h0_disp_new", 256'(disp_new0), 256'(IMG_D));
    check_eq("h0_frame_clr", 256'(frame_cnt0), 256'd0);
    step(1);
    check_eq("h0_idle", 256'(src_ready0), 256'd1);
    check_eq("h0_not_busy", 256'(busy0), 256'd0);
    check_eq("h0_no_timeout", 256'(timeout_err0), 256'd0);
    for (int k = 1; k <= 20; k++) begin
      vblank0 = 1'b1;
      step(1);
      vblank0 = 1'b0;
      step(1);
      if (k == 1 || k == 15 || k == 16 || k == 20)
        check_eq($sformatf("h0_frame_%0d", k), 256'(frame_cnt0), 256'((k > 15) ? 15 : k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
